// File: rtl/snd_dac_sched.sv
// snd_dac_sched: buffers command-bus sound samples and paces them to snd_dac; schedules vol_dac updates.
// Optional SND_VOL_RAMP_EN: volume walks one LSB per transfer toward the target instead of jumping.
//
// state        | meaning
// ST_IDLE      | waiting for a tick (sound) or a pending update (volume)
// ST_ISSUE     | one-cycle valid pulse to the DAC
// ST_WAIT_BUSY | waiting for DAC ready to drop, bounded by BUSY_TO
// ST_WAIT_DONE | DAC busy, waiting for ready to return
module snd_dac_sched #(
   parameter int         FIFO_AW   = 8,
   parameter int         LOW_WM    = 64,
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter int         BUSY_TO   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_wr,
   input  logic [7:0]         cmd_addr,
   input  logic [31:0]        cmd_data,
   output logic [7:0]         sound_data,
   output logic               sound_valid,
   input  logic               snddac_ready,
   output logic [7:0]         volume_data,
   output logic               volume_valid,
   input  logic               voldac_ready,
   output logic [FIFO_AW:0]   o_level,
   output logic               o_underrun,
   output logic               o_overflow,
   output logic               o_late,
   output logic               o_irq
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LVL_W = FIFO_AW + 1;
   localparam int TO_W  = $clog2(BUSY_TO + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE} dac_st_e;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [15:0]        div_q, div_d, tick_cnt_q, tick_cnt_d;
   logic               enable_q, enable_d;
   logic [7:0]         vol_target_q, vol_target_d;
   logic               vol_pending_q, vol_pending_d;
   dac_st_e            snd_st_q, snd_st_d, vol_st_q, vol_st_d;
   logic [TO_W-1:0]    snd_to_q, snd_to_d, vol_to_q, vol_to_d;
   logic [7:0]         sound_data_q, sound_data_d, volume_data_q, volume_data_d;
   logic               underrun_q, underrun_d, overflow_q, overflow_d, late_q, late_d;

   logic wr_snd, wr_div, wr_vol, wr_ctrl, push, pop, tick, clr_flags;
   logic set_underrun, set_late, vol_req;
   logic [7:0] vol_next;

   always_comb begin
      wr_snd    = cmd_wr && (cmd_addr == BASE_ADDR);
      wr_div    = cmd_wr && (cmd_addr == BASE_ADDR + 8'd1);
      wr_vol    = cmd_wr && (cmd_addr == BASE_ADDR + 8'd2);
      wr_ctrl   = cmd_wr && (cmd_addr == BASE_ADDR + 8'd3);
      clr_flags = wr_ctrl && cmd_data[1];
      tick      = enable_q && (tick_cnt_q == div_q);
      push      = wr_snd && (level_q <= LVL_W'(DEPTH - 4));

      div_d    = wr_div ? cmd_data[15:0] : div_q;
      enable_d = wr_ctrl ? cmd_data[0] : enable_q;
      tick_cnt_d = tick_cnt_q + 16'd1;
      if (wr_div || !enable_q || tick) tick_cnt_d = '0;

      snd_st_d     = snd_st_q;
      snd_to_d     = snd_to_q;
      sound_data_d = sound_data_q;
      pop          = 1'b0;
      set_underrun = 1'b0;
      case (snd_st_q)
         ST_IDLE: begin
            if (tick) begin
               if (level_q != '0) begin
                  pop          = 1'b1;
                  sound_data_d = mem_q[rd_ptr_q];
               end else begin
                  sound_data_d = 8'h80;
                  set_underrun = 1'b1;
               end
               snd_st_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            snd_to_d = TO_W'(BUSY_TO - 1);
            snd_st_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!snddac_ready)         snd_st_d = ST_WAIT_DONE;
            else if (snd_to_q == '0)   snd_st_d = ST_IDLE;
            else                       snd_to_d = snd_to_q - TO_W'(1);
         end
         ST_WAIT_DONE: if (snddac_ready) snd_st_d = ST_IDLE;
         default: snd_st_d = ST_IDLE;
      endcase
      set_late = tick && (snd_st_q != ST_IDLE);

      // push lands after the pop has already read the pre-push head
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(4);
         level_d  = level_d + LVL_W'(4);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
         level_d  = level_d - LVL_W'(1);
      end
      if (wr_ctrl && cmd_data[2]) begin
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end

      underrun_d = (underrun_q && !clr_flags) || set_underrun;
      overflow_d = (overflow_q && !clr_flags) || (wr_snd && !push);
      late_d     = (late_q && !clr_flags) || set_late;

`ifdef SND_VOL_RAMP_EN
      vol_req = vol_pending_q || (volume_data_q != vol_target_q);
      if (volume_data_q < vol_target_q)      vol_next = volume_data_q + 8'd1;
      else if (volume_data_q > vol_target_q) vol_next = volume_data_q - 8'd1;
      else                                   vol_next = volume_data_q;
`else
      vol_req  = vol_pending_q;
      vol_next = vol_target_q;
`endif

      vol_st_d      = vol_st_q;
      vol_to_d      = vol_to_q;
      volume_data_d = volume_data_q;
      vol_pending_d = vol_pending_q;
      case (vol_st_q)
         ST_IDLE: begin
            if (vol_req && voldac_ready) begin
               volume_data_d = vol_next;
               vol_pending_d = 1'b0;
               vol_st_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            vol_to_d = TO_W'(BUSY_TO - 1);
            vol_st_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!voldac_ready)         vol_st_d = ST_WAIT_DONE;
            else if (vol_to_q == '0)   vol_st_d = ST_IDLE;
            else                       vol_to_d = vol_to_q - TO_W'(1);
         end
         ST_WAIT_DONE: if (voldac_ready) vol_st_d = ST_IDLE;
         default: vol_st_d = ST_IDLE;
      endcase
      // a new write always re-arms, even on the cycle the previous one is taken
      vol_target_d = vol_target_q;
      if (wr_vol) begin
         vol_target_d  = cmd_data[7:0];
         vol_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int i = 0; i < 4; i++) mem_q[wr_ptr_q + FIFO_AW'(i)] <= cmd_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         div_q         <= '0;
         tick_cnt_q    <= '0;
         enable_q      <= 1'b0;
         vol_target_q  <= '0;
         vol_pending_q <= 1'b0;
         snd_st_q      <= ST_IDLE;
         vol_st_q      <= ST_IDLE;
         snd_to_q      <= '0;
         vol_to_q      <= '0;
         sound_data_q  <= 8'h80;
         volume_data_q <= '0;
         underrun_q    <= 1'b0;
         overflow_q    <= 1'b0;
         late_q        <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         div_q         <= div_d;
         tick_cnt_q    <= tick_cnt_d;
         enable_q      <= enable_d;
         vol_target_q  <= vol_target_d;
         vol_pending_q <= vol_pending_d;
         snd_st_q      <= snd_st_d;
         vol_st_q      <= vol_st_d;
         snd_to_q      <= snd_to_d;
         vol_to_q      <= vol_to_d;
         sound_data_q  <= sound_data_d;
         volume_data_q <= volume_data_d;
         underrun_q    <= underrun_d;
         overflow_q    <= overflow_d;
         late_q        <= late_d;
      end
   end

   assign sound_data   = sound_data_q;
   assign sound_valid  = (snd_st_q == ST_ISSUE);
   assign volume_data  = volume_data_q;
   assign volume_valid = (vol_st_q == ST_ISSUE);
   assign o_level      = level_q;
   assign o_underrun   = underrun_q;
   assign o_overflow   = overflow_q;
   assign o_late       = late_q;
   assign o_irq        = enable_q && (level_q <= LVL_W'(LOW_WM));

endmodule
